barrel_pool_ctrl: RTL and testbench
===================================

// Module: barrel_pool_ctrl
// PURPOSE
//  Parametrised slot allocator for NUM_SLOTS falling/rolling barrel instances.
//  Replaces free-running drop-counter indexing: each spawn request from kong goes to
//  the lowest-index free slot. Tracks per-slot liveness and reports pool statistics.
//  Filters per-slot raw mario/barrel collisions with a consecutive-sample counter,
//  producing a sticky game-over hit. Sits between kong/barrel instances and state_fsm.
// PARAMETERS
//  NUM_SLOTS   16   number of barrel slots (2..64)
//  IDX_W       4    slot index width, = clog2(NUM_SLOTS)
//  HIT_THRESH  128  consecutive sample_en ticks with a qualified hit needed to confirm (1..2^HCNT_W-1)
//  HCNT_W      8    width of the hit run counter
//  OVF_W       8    width of the spawn-overflow counter
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          asynchronous active-low reset
//  game_clr       in   1          synchronous clear (game in INITIAL state)
//  run_en         in   1          game RUNNING; spawn requests are ignored when low
//  spawn_req      in   1          spawn request; each high cycle is one request
//  retire         in   NUM_SLOTS  per-slot retire (barrel off-screen/over); level or pulse
//  hit_raw        in   NUM_SLOTS  per-slot raw collision with mario
//  hit_mask       in   1          collision disable (cheat switch)
//  sample_en      in   1          one-cycle collision sampling strobe
//  slot_start     out  NUM_SLOTS  one-hot, one-cycle start pulse to the allocated slot
//  slot_active    out  NUM_SLOTS  per-slot live flag
//  spawn_valid    out  1          one-cycle pulse: allocation made
//  spawn_idx      out  IDX_W      index of the last allocation (held)
//  spawn_full     out  1          one-cycle pulse: request dropped, no free slot
//  active_count   out  IDX_W+1    population count of slot_active
//  overflow_count out  OVF_W      dropped requests, saturating
//  hit_run        out  HCNT_W     current consecutive-hit run length
//  hit_confirmed  out  1          sticky confirmed collision
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0; run counter 0. game_clr=1 gives the same result
//   synchronously and takes priority over every other input in that cycle.
//  Allocation: spawn_req=1 and run_en=1 at edge t. Select the lowest i with slot_active[i]=0,
//   using the registered state from before edge t. Registered at edge t: slot_active[i]=1,
//   slot_start=1<<i, spawn_valid=1, spawn_idx=i. Outputs are visible for cycle t+1 only,
//   except slot_active and spawn_idx, which persist.
//  Full: no free slot -> spawn_full=1 for one cycle; overflow_count+1, saturating at 2^OVF_W-1.
//   slot_start=0, spawn_valid=0, spawn_idx unchanged.
//  run_en=0: spawn_req ignored entirely (no pulses, no overflow count).
//  Retire: retire[i]=1 at edge t clears slot_active[i] at that edge. No effect if already inactive.
//  Retire and spawn in the same cycle: a slot retiring this cycle is not eligible for this
//   allocation. A slot retiring this cycle and a different slot allocated this cycle are both applied.
//  active_count is the registered popcount of the next slot_active value; it is consistent
//   with slot_active in the same cycle.
//  Hit filter: qualified hit q = |(hit_raw & slot_active) & ~hit_mask.
//   - On a sample_en edge: q=1 -> hit_run <= min(hit_run+1, HIT_THRESH); q=0 -> hit_run <= 0.
//   - When the new value equals HIT_THRESH, hit_confirmed <= 1 at the same edge.
//   - hit_confirmed stays set until rst_n or game_clr.
//   - Without sample_en, hit_run holds its value.
//   - hit_mask=1 forces hit_run to 0 on every clk edge and blocks setting hit_confirmed.
//     An already-set hit_confirmed is not cleared.
//  All updates are single-cycle registered; no combinational path from inputs to outputs.
// TESTING
//  1. Reset, run_en=1, three spawn_req pulses:
//     -> slot_start=0x0001, 0x0002, 0x0004 each one cycle after its request;
//        spawn_idx=0,1,2; active_count=3.
//  2. Pool full (all 16 active), spawn_req x300:
//     -> spawn_full pulses 300 times; overflow_count saturates at 255; slot_active unchanged.
//  3. Slots 0-3 active, retire[1]=1 and spawn_req in the same cycle:
//     -> slot 1 cleared, allocation goes to slot 4; next spawn_req -> slot 1.
//  4. Slot 5 active, hit_raw[5]=1, 128 sample_en strobes:
//     -> hit_confirmed rises on the 128th strobe; a miss at strobe 100 resets hit_run to 0
//        and delays confirmation by 100 strobes.
//  5. hit_raw set on an inactive slot, or hit_mask=1 -> hit_run stays 0, hit_confirmed stays 0.
//  6. rst_n pulsed low mid-run with slots active and hit_run=60:
//     -> all outputs 0 immediately, without waiting for a clk edge; game_clr gives the same
//        result on the next edge.

Source files
------------

// File: rtl/barrel_pool_ctrl.sv
// barrel_pool_ctrl: slot allocator and collision filter for the barrel pool.
// Each spawn request from kong goes to the lowest-index free slot. The block
// tracks which slots are live, counts requests dropped on a full pool, and
// debounces per-slot mario collisions into a sticky game-over hit.
module barrel_pool_ctrl #(
    parameter int NUM_SLOTS  = 16,
    parameter int IDX_W      = 4,
    parameter int HIT_THRESH = 128,
    parameter int HCNT_W     = 8,
    parameter int OVF_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 game_clr,
    input  logic                 run_en,
    input  logic                 spawn_req,
    input  logic [NUM_SLOTS-1:0] retire,
    input  logic [NUM_SLOTS-1:0] hit_raw,
    input  logic                 hit_mask,
    input  logic                 sample_en,
    output logic [NUM_SLOTS-1:0] slot_start,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic                 spawn_valid,
    output logic [IDX_W-1:0]     spawn_idx,
    output logic                 spawn_full,
    output logic [IDX_W:0]       active_count,
    output logic [OVF_W-1:0]     overflow_count,
    output logic [HCNT_W-1:0]    hit_run,
    output logic                 hit_confirmed
);

    localparam int                CNT_W    = IDX_W + 1;
    localparam logic [HCNT_W-1:0] THRESH_V = HCNT_W'(HIT_THRESH);

    logic [NUM_SLOTS-1:0] free_slots;
    logic                 alloc_found;
    logic [IDX_W-1:0]     alloc_idx;
    logic                 do_spawn;
    logic                 grant;
    logic [NUM_SLOTS-1:0] alloc_onehot;
    logic [NUM_SLOTS-1:0] next_active;
    logic [CNT_W-1:0]     next_count;

    logic                 hit_q;
    logic [HCNT_W-1:0]    run_inc;
    logic [HCNT_W-1:0]    next_run;
    logic                 confirm_set;

    // Lowest-index free slot search, next liveness vector and its popcount.
    // A slot retiring this cycle is excluded so it cannot be reallocated at once.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alloc_found = 1'b0;
        alloc_idx   = '0;
        free_slots  = ~slot_active & ~retire;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_slots[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
        do_spawn     = spawn_req & run_en;
        grant        = do_spawn & alloc_found;
        alloc_onehot = grant ? (NUM_SLOTS'(1) << alloc_idx) : '0;
        next_active  = (slot_active & ~retire) | alloc_onehot;
        next_count   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            next_count = next_count + CNT_W'(next_active[i]);
        end
    end

    // Collision run-length filter: saturating count of qualified hits per strobe.
    always_comb begin
        hit_q       = (|(hit_raw & slot_active)) & ~hit_mask;
        run_inc     = (hit_run >= THRESH_V) ? THRESH_V : hit_run + HCNT_W'(1);
        next_run    = hit_run;
        confirm_set = 1'b0;
        if (hit_mask) begin
            next_run = '0;
        end else if (sample_en) begin
            next_run    = hit_q ? run_inc : '0;
            confirm_set = hit_q && (run_inc == THRESH_V);
        end
    end

    // Pool state and one-cycle allocation/overflow pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state uses non-blocking assignments so every flop sees pre-edge values.
        if (!rst_n) begin
            slot_active    <= '0;
            slot_start     <= '0;
            spawn_valid    <= 1'b0;
            spawn_idx      <= '0;
            spawn_full     <= 1'b0;
            active_count   <= '0;
            overflow_count <= '0;
        end else if (game_clr) begin
            slot_active    <= '0;
            slot_start     <= '0;
            spawn_valid    <= 1'b0;
            spawn_idx      <= '0;
            spawn_full     <= 1'b0;
            active_count   <= '0;
            overflow_count <= '0;
        end else begin
            slot_active  <= next_active;
            active_count <= next_count;
            slot_start   <= alloc_onehot;
            spawn_valid  <= grant;
            spawn_full   <= do_spawn & ~alloc_found;
            if (grant) begin
                spawn_idx <= alloc_idx;
            end
            if (do_spawn && !alloc_found && (overflow_count != {OVF_W{1'b1}})) begin
                overflow_count <= overflow_count + OVF_W'(1);
            end
        end
    end

    // Hit run counter and sticky confirmation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_run       <= '0;
            hit_confirmed <= 1'b0;
        end else if (game_clr) begin
            hit_run       <= '0;
            hit_confirmed <= 1'b0;
        end else begin
            hit_run <= next_run;
            if (confirm_set) begin
                hit_confirmed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_barrel_pool_ctrl.sv
// Scoreboard bench for barrel_pool_ctrl: stimulus pushes hand-computed
// allocation/overflow events, a negedge monitor pops and compares them.
module tb_barrel_pool_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_clr = 1'b0;
    logic        run_en = 1'b0;
    logic        spawn_req = 1'b0;
    logic [15:0] retire = '0;
    logic [15:0] hit_raw = '0;
    logic        hit_mask = 1'b0;
    logic        sample_en = 1'b0;
    logic [15:0] slot_start;
    logic [15:0] slot_active;
    logic        spawn_valid;
    logic [3:0]  spawn_idx;
    logic        spawn_full;
    logic [4:0]  active_count;
    logic [7:0]  overflow_count;
    logic [7:0]  hit_run;
    logic        hit_confirmed;

    typedef struct packed {
        logic        full;
        logic [3:0]  idx;
        logic [15:0] start;
        logic [4:0]  cnt;
        logic [7:0]  ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    barrel_pool_ctrl dut (
        .clk(clk), .rst_n(rst_n), .game_clr(game_clr), .run_en(run_en),
        .spawn_req(spawn_req), .retire(retire), .hit_raw(hit_raw),
        .hit_mask(hit_mask), .sample_en(sample_en), .slot_start(slot_start),
        .slot_active(slot_active), .spawn_valid(spawn_valid), .spawn_idx(spawn_idx),
        .spawn_full(spawn_full), .active_count(active_count),
        .overflow_count(overflow_count), .hit_run(hit_run), .hit_confirmed(hit_confirmed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every allocation or overflow pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && (spawn_valid || spawn_full)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {62'd0, spawn_valid, spawn_full}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("evt_full", 64'(spawn_full), 64'(mon_e.full));
                check("evt_valid", 64'(spawn_valid), 64'(!mon_e.full));
                if (mon_e.full) begin
                    check("full_start", 64'(slot_start), 64'd0);
                    check("full_ovf", 64'(overflow_count), 64'(mon_e.ovf));
                end else begin
                    check("alloc_idx", 64'(spawn_idx), 64'(mon_e.idx));
                    check("alloc_start", 64'(slot_start), 64'(mon_e.start));
                    check("alloc_cnt", 64'(active_count), 64'(mon_e.cnt));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_alloc(input int idx, input int cnt);
        exp_t e;
        logic [15:0] one;
        one     = 16'd1;
        e.full  = 1'b0;
        e.idx   = 4'(idx);
        e.start = one << idx;
        e.cnt   = 5'(cnt);
        e.ovf   = 8'd0;
        exp_q.push_back(e);
    endtask

    task automatic push_full(input int ovf);
        exp_t e;
        e.full  = 1'b1;
        e.idx   = 4'd0;
        e.start = 16'd0;
        e.cnt   = 5'd0;
        e.ovf   = 8'(ovf);
        exp_q.push_back(e);
    endtask

    // n back-to-back spawns into a pool whose slots 0..first-1 are live.
    task automatic spawn_run(input int first, input int n);
        for (int k = 0; k < n; k++) push_alloc(first + k, first + k + 1);
        spawn_req = 1'b1;
        repeat (n) tick();
        spawn_req = 1'b0;
    endtask

    task automatic strobe(input int n);
        repeat (n) begin
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
        end
    endtask

    task automatic clear_game();
        hit_raw  = '0;
        hit_mask = 1'b0;
        retire   = '0;
        game_clr = 1'b1;
        tick();
        game_clr = 1'b0;
        tick();
    endtask

    task automatic check_zero(input string name);
        check(name, {4'd0, slot_start, slot_active, spawn_valid, spawn_full, spawn_idx,
                     active_count, overflow_count, hit_run, hit_confirmed}, 64'd0);
    endtask

    initial begin
        // Reset state.
        #3;
        check_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_en = 1'b1;
        tick();

        // 1: three spawns go to slots 0,1,2.
        spawn_run(0, 3);
        check("t1_active", 64'(slot_active), 64'h0007);
        check("t1_count", 64'(active_count), 64'd3);
        tick();
        check("t1_idx_held", 64'(spawn_idx), 64'd2);
        check("t1_start_pulse_gone", 64'(slot_start), 64'd0);

        // run_en low: requests ignored.
        run_en = 1'b0;
        spawn_req = 1'b1;
        repeat (4) tick();
        spawn_req = 1'b0;
        run_en = 1'b1;
        check("ignored_active", 64'(slot_active), 64'h0007);
        check("ignored_ovf", 64'(overflow_count), 64'd0);

        // 2: fill the pool, then 300 requests all overflow.
        spawn_run(3, 13);
        check("t2_active_full", 64'(slot_active), 64'hFFFF);
        check("t2_count_full", 64'(active_count), 64'd16);
        for (int k = 1; k <= 300; k++) push_full(k > 255 ? 255 : k);
        spawn_req = 1'b1;
        repeat (300) tick();
        spawn_req = 1'b0;
        tick();
        check("t2_ovf_sat", 64'(overflow_count), 64'd255);
        check("t2_active_kept", 64'(slot_active), 64'hFFFF);
        check("t2_idx_kept", 64'(spawn_idx), 64'd15);

        // 3: retire slot 1 while spawning; allocation skips it.
        clear_game();
        check("clr_ovf", 64'(overflow_count), 64'd0);
        spawn_run(0, 4);
        retire = 16'h0002;
        spawn_req = 1'b1;
        push_alloc(4, 4);
        tick();
        retire = '0;
        check("t3_active_mix", 64'(slot_active), 64'h001D);
        push_alloc(1, 5);
        tick();
        spawn_req = 1'b0;
        check("t3_active_after", 64'(slot_active), 64'h001F);
        check("t3_count_after", 64'(active_count), 64'd5);

        // 4a: 128 consecutive hits on live slot 5.
        clear_game();
        spawn_run(0, 6);
        hit_raw = 16'h0020;
        strobe(127);
        tick();
        tick();
        check("t4_run127_held", 64'(hit_run), 64'd127);
        check("t4_not_yet", 64'(hit_confirmed), 64'd0);
        strobe(1);
        check("t4_confirm", 64'(hit_confirmed), 64'd1);
        check("t4_run_thresh", 64'(hit_run), 64'd128);
        strobe(3);
        check("t4_run_sat", 64'(hit_run), 64'd128);
        hit_mask = 1'b1;
        tick();
        check("t4_mask_run0", 64'(hit_run), 64'd0);
        check("t4_mask_sticky", 64'(hit_confirmed), 64'd1);
        hit_mask = 1'b0;

        // 4b: miss at strobe 100 delays confirmation to strobe 228.
        clear_game();
        spawn_run(0, 6);
        hit_raw = 16'h0020;
        strobe(99);
        check("t4b_run99", 64'(hit_run), 64'd99);
        hit_raw = 16'h0000;
        strobe(1);
        check("t4b_miss_run0", 64'(hit_run), 64'd0);
        hit_raw = 16'h0020;
        strobe(127);
        check("t4b_not_at_227", 64'(hit_confirmed), 64'd0);
        strobe(1);
        check("t4b_confirm_228", 64'(hit_confirmed), 64'd1);

        // 5: hits on an inactive slot, and masked hits, never count.
        clear_game();
        spawn_run(0, 1);
        hit_raw = 16'h0020;
        strobe(5);
        check("t5_inactive_run", 64'(hit_run), 64'd0);
        hit_raw = 16'h0001;
        strobe(3);
        check("t5_live_run3", 64'(hit_run), 64'd3);
        hit_mask = 1'b1;
        tick();
        check("t5_mask_no_strobe", 64'(hit_run), 64'd0);
        strobe(130);
        check("t5_mask_run", 64'(hit_run), 64'd0);
        check("t5_mask_confirm", 64'(hit_confirmed), 64'd0);
        hit_mask = 1'b0;

        // 6: async reset mid-run, then synchronous clear with competing inputs.
        clear_game();
        spawn_run(0, 3);
        hit_raw = 16'h0001;
        strobe(60);
        check("t6_run60", 64'(hit_run), 64'd60);
        rst_n = 1'b0;
        #2;
        check_zero("t6_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        hit_raw = '0;
        tick();
        spawn_run(0, 3);
        hit_raw = 16'h0001;
        strobe(60);
        game_clr = 1'b1;
        spawn_req = 1'b1;
        sample_en = 1'b1;
        retire = 16'h0001;
        tick();
        check_zero("t6_game_clr");
        game_clr = 1'b0;
        spawn_req = 1'b0;
        sample_en = 1'b0;
        retire = '0;
        hit_raw = '0;

        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
